// File: rtl/md_sequencer_if.sv
// rtl/md_sequencer_if.sv - E-stage multiply/divide request and HI/LO result bundle
interface md_sequencer_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_data, rt_data, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, rs_data, rt_data, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle MULT/DIV sequencer owning the HI/LO registers
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    md_sequencer_if.slave     md
);
    localparam int MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAX_C > 2) ? $clog2(MAX_C) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      pend_hi, pend_lo;
    logic             no_write;

    logic             busy;
    logic             accept;
    logic [31:0]      rs, rt;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      rt_safe;
    logic [31:0]      a_mag, b_mag, q_mag, r_mag;
    logic [31:0]      quo_s, rem_s, quo_u, rem_u;

    assign rs     = md.rs_data;
    assign rt     = md.rt_data;
    assign busy   = (state != S_IDLE);
    assign accept = md.start & ~md.cancel & ~busy & (md.md_op != 3'd0) & (md.md_op != 3'd7);

    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Zero divisor is replaced so the dividers stay defined; the result is discarded anyway.
    assign rt_safe = (rt == 32'd0) ? 32'd1 : rt;
    assign a_mag   = rs[31] ? (32'd0 - rs) : rs;
    assign b_mag   = rt_safe[31] ? (32'd0 - rt_safe) : rt_safe;
    assign q_mag   = a_mag / b_mag;
    assign r_mag   = a_mag % b_mag;
    assign quo_s   = (rs[31] ^ rt_safe[31]) ? (32'd0 - q_mag) : q_mag;
    assign rem_s   = rs[31] ? (32'd0 - r_mag) : r_mag;
    assign quo_u   = rs / rt_safe;
    assign rem_u   = rs % rt_safe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            counter  <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
            no_write <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (md.md_op)
                            OP_MULT, OP_MULTU: begin
                                {pend_hi, pend_lo} <= (md.md_op == OP_MULT) ? prod_s : prod_u;
                                no_write <= 1'b0;
                                counter  <= CNT_W'(MULT_CYCLES - 1);
                                state    <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_lo  <= (md.md_op == OP_DIV) ? quo_s : quo_u;
                                pend_hi  <= (md.md_op == OP_DIV) ? rem_s : rem_u;
                                no_write <= (rt == 32'd0);
                                counter  <= CNT_W'(DIV_CYCLES - 1);
                                state    <= S_DIV;
                            end
                            OP_MTHI: hi_q <= rs;
                            OP_MTLO: lo_q <= rs;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (counter == '0) begin
                        if (!no_write) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        state <= S_IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign md.busy = busy;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - self-checking bench for md_sequencer against an arithmetic reference model
module tb_md_sequencer;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_hi, exp_lo;

    md_sequencer_if bus();

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_state(input string tag, input logic b, input logic [31:0] h, input logic [31:0] l);
        check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
        check({tag, ".hi"}, bus.hi, h);
        check({tag, ".lo"}, bus.lo, l);
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (op)
            3'd1: begin sp = sa * sb; res = sp; end
            3'd2: begin up = ua * ub; res = up; end
            3'd3: begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
            3'd4: begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Issue one op at a negedge; optionally inject a second start during busy cycle inj_at.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cxl, input int inj_at, input logic [2:0] inj_op,
                         input logic [31:0] inj_rs, input logic inj_cxl);
        int          nb;
        logic        acc;
        logic [31:0] new_hi, new_lo;
        logic [63:0] r;
        acc    = !cxl && (op >= 3'd1) && (op <= 3'd6);
        nb     = 0;
        new_hi = exp_hi;
        new_lo = exp_lo;
        if (acc) begin
            if (op == 3'd5) new_hi = a;
            else if (op == 3'd6) new_lo = a;
            else begin
                nb = (op <= 3'd2) ? MC : DC;
                if (!(op >= 3'd3 && b == 32'd0)) begin
                    r = md_result(op, a, b);
                    new_hi = r[63:32];
                    new_lo = r[31:0];
                end
            end
        end
        bus.start   = 1'b1;
        bus.md_op   = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.cancel  = cxl;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bus.start = (i == inj_at);
            if (i == inj_at) begin
                bus.md_op   = inj_op;
                bus.rs_data = inj_rs;
                bus.cancel  = inj_cxl;
            end else begin
                bus.cancel = 1'b0;
            end
            check_state({tag, ".inflight"}, 1'b1, exp_hi, exp_lo);
            @(negedge clk);
        end
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        exp_hi = new_hi;
        exp_lo = new_lo;
        check_state({tag, ".done"}, 1'b0, exp_hi, exp_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        c;
        bus.start   = 1'b0;
        bus.md_op   = 3'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.cancel  = 1'b0;
        reset = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (2) @(negedge clk);
        check_state("reset", 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("mult", 3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        check_state("mult_const", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        do_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        check_state("multu_const", 1'b0, 32'h00000001, 32'hFFFFFFFE);
        do_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        check_state("div_const", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu", 3'd4, 32'd7, 32'd2, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        check_state("divu_const", 1'b0, 32'd1, 32'd3);
        do_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        check_state("div_ovf_const", 1'b0, 32'd0, 32'h80000000);

        do_op("mthi11", 3'd5, 32'h11, 32'd0, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        do_op("mtlo22", 3'd6, 32'h22, 32'd0, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        do_op("div0", 3'd3, 32'd1234, 32'd0, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        check_state("div0_const", 1'b0, 32'h11, 32'h22);

        do_op("mthi", 3'd5, 32'hABCD0000, 32'd0, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        do_op("mtlo", 3'd6, 32'h1234, 32'd0, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        check_state("mt_const", 1'b0, 32'hABCD0000, 32'h1234);

        do_op("cancel", 3'd1, 32'd9, 32'd9, 1'b1, -1, 3'd0, 32'd0, 1'b0);
        do_op("nop0", 3'd0, 32'hDEAD, 32'd3, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        do_op("nop7", 3'd7, 32'hBEEF, 32'd3, 1'b0, -1, 3'd0, 32'd0, 1'b0);
        do_op("mthi_busy", 3'd1, 32'd1000, 32'd3000, 1'b0, 2, 3'd5, 32'h5555AAAA, 1'b0);
        check_state("mthi_busy_const", 1'b0, 32'd0, 32'd3000000);
        do_op("cancel_busy", 3'd4, 32'd100, 32'd7, 1'b0, 4, 3'd0, 32'd0, 1'b1);
        do_op("last_busy_start", 3'd2, 32'd6, 32'd7, 1'b0, MC - 1, 3'd6, 32'h77, 1'b0);

        // Asynchronous reset in the middle of a divide.
        bus.start = 1'b1; bus.md_op = 3'd3; bus.rs_data = 32'd50; bus.rt_data = 32'd3; bus.cancel = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_state("pre_reset", 1'b1, exp_hi, exp_lo);
        #2 reset = 1'b1;
        #1 exp_hi = 32'd0;
        exp_lo = 32'd0;
        check_state("async_reset", 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (DC + 2) @(negedge clk);
        check_state("post_reset", 1'b0, 32'd0, 32'd0);

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            c = ($urandom_range(0, 7) == 0);
            do_op("rand", op, a, b, c, -1, 3'd0, 32'd0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer in the E stage.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over a fixed number of cycles.
- Applies MTHI/MTLO writes immediately.
- Exports `busy` so the pipeline stall logic can hold MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; legal range ≥1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is an MD operation this cycle.
- md_op  input  3  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 0 and 7 are no-op.
- rs_data  input  32  forwarded GPR[rs].
- rt_data  input  32  forwarded GPR[rt].
- cancel  input  1  exception/interrupt flush of the E-stage instruction this cycle.
- busy  output  1  operation in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high on `reset`.
- Reset state:
  - state=IDLE, hi=0, lo=0, busy=0, counter=0.
  - Pending result registers are cleared.
  - Reset mid-operation aborts the operation; no HI/LO update occurs.
- Accept condition:
  - `accept = start & ~cancel & ~busy & md_op in 1..6`. Sampled at the rising edge.
  - `start` while busy is ignored. The stall logic guarantees this does not happen; the bench checks that it is harmless.
- States: IDLE, MUL, DIV.
- IDLE, MUL/MULTU accepted:
  - Compute the 64-bit product at the accept edge. MULT sign-extends both operands; MULTU zero-extends both.
  - Latch the product into pend_hi/pend_lo.
  - Load counter=MULT_CYCLES-1; go to MUL.
- IDLE, DIV/DIVU accepted:
  - Latch quotient into pend_lo and remainder into pend_hi. Load counter=DIV_CYCLES-1; go to DIV.
  - DIV is signed, truncates toward zero, and the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives pend_lo=0x80000000, pend_hi=0.
  - Divisor == 0: set a no-write flag so HI/LO stay unchanged at completion. Busy timing is still the full DIV_CYCLES.
- IDLE, MTHI/MTLO accepted:
  - hi (or lo) <= rs_data at that edge. No busy, stay in IDLE.
- MUL/DIV:
  - busy=1 (combinational from state ≠ IDLE).
  - Each edge: if counter==0, write pend_hi/pend_lo to hi/lo (unless no-write) and go to IDLE; otherwise counter--.
- Timing: accept at edge 0 gives busy=1 during cycles 1..N and hi/lo updated with busy=0 from cycle N+1, where N=MULT_CYCLES or DIV_CYCLES.
- hi/lo hold their old values throughout busy. They change only at the completion edge or on an MTHI/MTLO accept.
- `cancel` only blocks acceptance in its own cycle. An operation already in flight always completes; `cancel` during busy has no effect.
- `start` with md_op 0 or 7: no state change.
- No 2-port hazards: only one writer of HI/LO per edge by construction (an MTHI/MTLO cannot be accepted while busy).

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD (-3), rt=5 → busy high for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=7, rt=2 → lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV with rt=0 after hi=0x11, lo=0x22 → busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- MTHI rs=0xABCD0000, then next cycle MTLO rs=0x1234 → hi=0xABCD0000 and lo=0x1234, each visible the cycle after its accept; busy stays 0.
- start=1 with cancel=1 on MULT → no busy, hi/lo unchanged.
- Start MULT, then assert start+MTHI during busy → MTHI ignored; final hi/lo equal the product.
- Assert reset at busy cycle 3 of a DIV → hi=lo=0, busy=0 immediately (asynchronously), no later update.
